// File: rtl/remote_pkg.sv
// Shared definitions for the remote key-event controller.
//   - key_type encodings carried on the consumer interface
//   - FSM state type for the key tracker
//   - event word layout: {type[1:0], code[7:0]} = 10 bits
package remote_pkg;

  localparam int unsigned KeyCodeW = 8;
  localparam int unsigned KeyTypeW = 2;
  localparam int unsigned KeyEvtW  = KeyTypeW + KeyCodeW;

  localparam logic [KeyTypeW-1:0] KEY_PRESS   = 2'd0;
  localparam logic [KeyTypeW-1:0] KEY_HOLD    = 2'd1;
  localparam logic [KeyTypeW-1:0] KEY_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld,
    StSwap
  } key_state_e;

  function automatic logic [KeyEvtW-1:0] key_evt_pack(input logic [KeyTypeW-1:0] kind,
                                                      input logic [KeyCodeW-1:0] code);
    return {kind, code};
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO with count-based full/empty.
// The head entry is presented on rd_data_o whenever valid_o is high; a write is
// only visible at the head from the following cycle (no bypass path).
// A write while full is dropped unless a read frees a slot in the same cycle;
// dropped writes set the sticky ovf_o, which clears only on reset.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i         push wr_data_i
//   rd_en_i         pop the head (ignored when empty)
//   rd_data_o       head entry
//   valid_o         FIFO not empty
//   ovf_o           sticky overflow flag
module key_evt_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             valid_o,
  output logic             ovf_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, do_wr, do_rd;

  always_comb begin
    full     = (count_q == CntW'(Depth));
    empty    = (count_q == '0);
    do_rd    = rd_en_i && !empty;
    // A simultaneous read frees the slot, so a write into a full FIFO is accepted.
    do_wr    = wr_en_i && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CntW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CntW'(1);
    end
    ovf_d    = ovf_q | (wr_en_i & ~do_wr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = !empty;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/remote_key_ctrl.sv
// Key-event controller behind the NEC IR decoder.
// Turns data_en/repeat_en pulses plus the 8-bit key code into PRESS / HOLD / RELEASE
// events, buffers them in key_evt_fifo and hands them out over valid/ready.
// Build option: define REMOTE_HOLD_EN to enable the HELD state, HOLD events, the
// repeat counter and hold_led_o. Without it repeats only keep the key alive.
// Ports:
//   sys_clk_i, sys_rst_n_i   clock, asynchronous active-low reset
//   data_en_i, data_i        new decoded frame and its key code
//   repeat_en_i              NEC repeat frame
//   key_valid_o/key_ready_i  event handshake; key_code_o/key_type_o = head event
//   disp_data_o              last pressed code
//   hold_led_o               high while the key is in HELD
//   ovf_o                    sticky: an event was dropped on a full FIFO
module remote_key_ctrl
  import remote_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned RELEASE_MS = 120,
  parameter int unsigned HOLD_RPT   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_n_i,
  input  logic                data_en_i,
  input  logic [KeyCodeW-1:0] data_i,
  input  logic                repeat_en_i,
  output logic                key_valid_o,
  input  logic                key_ready_i,
  output logic [KeyCodeW-1:0] key_code_o,
  output logic [KeyTypeW-1:0] key_type_o,
  output logic [KeyCodeW-1:0] disp_data_o,
  output logic                hold_led_o,
  output logic                ovf_o
);

  localparam int unsigned Reload = CLK_FREQ / 1000 * RELEASE_MS;
  localparam int unsigned TimerW = $clog2(Reload + 1);

  key_state_e          state_q, state_d;
  logic [KeyCodeW-1:0] cur_code_q, cur_code_d;
  logic [KeyCodeW-1:0] disp_q, disp_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                evt_wr;
  logic [KeyEvtW-1:0]  evt_data;
  logic [KeyEvtW-1:0]  head;

`ifdef REMOTE_HOLD_EN
  localparam int unsigned RptW = (HOLD_RPT > 0) ? $clog2(HOLD_RPT + 1) : 1;
  logic [RptW-1:0] rpt_q, rpt_d, rpt_inc;
`endif

  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    disp_d     = disp_q;
    // Free-running down-count; any reload below overrides it.
    timer_d    = (timer_q != '0) ? timer_q - TimerW'(1) : '0;
    evt_wr     = 1'b0;
    evt_data   = '0;
`ifdef REMOTE_HOLD_EN
    rpt_d      = rpt_q;
    rpt_inc    = (rpt_q == RptW'(HOLD_RPT)) ? rpt_q : rpt_q + RptW'(1);
`endif

    unique case (state_q)
      StIdle: begin
        // Orphan repeats are ignored here.
        if (data_en_i) begin
          evt_wr     = 1'b1;
          evt_data   = key_evt_pack(KEY_PRESS, data_i);
          cur_code_d = data_i;
          disp_d     = data_i;
          timer_d    = TimerW'(Reload);
`ifdef REMOTE_HOLD_EN
          rpt_d      = '0;
`endif
          state_d    = StPressed;
        end
      end

      StPressed, StHeld: begin
        if (data_en_i && (data_i != cur_code_q)) begin
          // New key: release the old one now, press the new one from StSwap.
          evt_wr     = 1'b1;
          evt_data   = key_evt_pack(KEY_RELEASE, cur_code_q);
          cur_code_d = data_i;
          state_d    = StSwap;
        end else if (data_en_i || repeat_en_i) begin
          // Same-code frame or repeat; takes priority over an expiring timer.
          timer_d = TimerW'(Reload);
`ifdef REMOTE_HOLD_EN
          rpt_d = rpt_inc;
          if (state_q == StHeld) begin
            evt_wr   = 1'b1;
            evt_data = key_evt_pack(KEY_HOLD, cur_code_q);
          end else if (rpt_inc == RptW'(HOLD_RPT)) begin
            evt_wr   = 1'b1;
            evt_data = key_evt_pack(KEY_HOLD, cur_code_q);
            state_d  = StHeld;
          end
`endif
        end else if (timer_q == TimerW'(1)) begin
          // Timer reaches zero at this edge: silence long enough, key released.
          evt_wr   = 1'b1;
          evt_data = key_evt_pack(KEY_RELEASE, cur_code_q);
          state_d  = StIdle;
        end
      end

      StSwap: begin
        // Single-cycle state; pulses arriving now are dropped.
        evt_wr   = 1'b1;
        evt_data = key_evt_pack(KEY_PRESS, cur_code_q);
        disp_d   = cur_code_q;
        timer_d  = TimerW'(Reload);
`ifdef REMOTE_HOLD_EN
        rpt_d    = '0;
`endif
        state_d  = StPressed;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q    <= StIdle;
      cur_code_q <= '0;
      disp_q     <= '0;
      timer_q    <= '0;
`ifdef REMOTE_HOLD_EN
      rpt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      disp_q     <= disp_d;
      timer_q    <= timer_d;
`ifdef REMOTE_HOLD_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  key_evt_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (KeyEvtW)
  ) u_fifo (
    .clk_i     (sys_clk_i),
    .rst_ni    (sys_rst_n_i),
    .wr_en_i   (evt_wr),
    .wr_data_i (evt_data),
    .rd_en_i   (key_ready_i),
    .rd_data_o (head),
    .valid_o   (key_valid_o),
    .ovf_o     (ovf_o)
  );

  assign key_code_o  = head[KeyCodeW-1:0];
  assign key_type_o  = head[KeyEvtW-1:KeyCodeW];
  assign disp_data_o = disp_q;

`ifdef REMOTE_HOLD_EN
  assign hold_led_o = (state_q == StHeld);
`else
  assign hold_led_o = 1'b0;
`endif

endmodule

// File: doc/remote_key_ctrl.md
# remote_key_ctrl

Key-event controller behind the NEC infrared decoder. It converts the decoder's `data_en`/`repeat_en` pulses and 8-bit key code into press, hold and release events. Events are buffered in a small FIFO and handed to a consumer over a valid/ready handshake. It also registers the last pressed code for the segment-display path and drives a "key held" LED.

## Interface

- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `RELEASE_MS`, 120: silence after the last frame or repeat before a release is declared. The NEC repeat period is 108 ms.
- `HOLD_RPT`, 3: repeat frames after a press before the first HOLD event.
- `FIFO_DEPTH`, 4: event FIFO depth, power of two, ≥2.
- `sys_clk` input 1: the single clock; all logic is on the rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `data_en` input 1: one-cycle pulse, a new frame has been decoded.
- `data` input 8: key code, valid while `data_en`=1.
- `repeat_en` input 1: one-cycle pulse, a repeat frame has been received.
- `key_valid` output 1: event available at the FIFO head.
- `key_ready` input 1: consumer accepts the head event.
- `key_code` output 8: code of the head event.
- `key_type` output 2: type of the head event. 0 = PRESS, 1 = HOLD, 2 = RELEASE.
- `disp_data` output 8: last pressed code, for the display.
- `hold_led` output 1: high while the FSM is in HELD.
- `ovf` output 1: sticky; an event was dropped because the FIFO was full.

## Operation

- Reset values: FSM=IDLE, FIFO empty, `key_valid`=0, `key_code`=0, `key_type`=0, `disp_data`=0, `hold_led`=0, `ovf`=0, all counters 0.
- FSM states: IDLE, PRESSED, HELD, SWAP.
- IDLE:
  - `data_en` → enqueue PRESS(`data`), latch `cur_code`, load `disp_data`, reload the timer, clear the repeat counter, go to PRESSED.
  - `repeat_en` is ignored (orphan repeat).
- PRESSED or HELD, on `data_en`:
  - Same code: treated as a repeat.
  - Different code: enqueue RELEASE(`cur_code`), latch the new code, go to SWAP.
- SWAP: always lasts one cycle. Enqueue PRESS(`cur_code`), load `disp_data`, reload the timer, go to PRESSED. Pulses arriving during SWAP are ignored.
- Repeat handling in PRESSED or HELD:
  - Every repeat reloads the timer.
  - The repeat counter increments, saturating at `HOLD_RPT`.
  - PRESSED: when the counter reaches `HOLD_RPT`, enqueue HOLD and go to HELD.
  - HELD: every further repeat enqueues HOLD.
- Timeout:
  - The timer is a down-counter of width `$clog2(CLK_FREQ/1000*RELEASE_MS+1)`, reloaded with `CLK_FREQ/1000*RELEASE_MS`.
  - On reaching 0 in PRESSED or HELD, enqueue RELEASE(`cur_code`) and go to IDLE.
- Simultaneous events:
  - `data_en` and `repeat_en` in the same cycle: `data_en` wins.
  - `data_en` or `repeat_en` in the same cycle the timer hits 0: the pulse wins and the timer reloads, so no release is issued.
- FIFO:
  - A write when full is dropped and sets `ovf`.
  - Simultaneous read and write when full is allowed: the read frees the slot.
  - `ovf` clears only on reset.
- `disp_data` changes only on PRESS.

## Timing

- Pulse sampled at edge N: event written at edge N, `key_valid`=1 after edge N. Latency is 1 cycle.
- Code change: RELEASE is written at edge N and PRESS at edge N+1.
- Handshake transfer occurs at an edge where `key_valid`=1 and `key_ready`=1.
- `key_code`/`key_type` are stable while `key_valid`=1 and `key_ready`=0.
- The FIFO is not first-word-fall-through bypassed. An event written at edge N is poppable at edge N+1 at the earliest.
- Release latency: exactly `CLK_FREQ/1000*RELEASE_MS` cycles after the last reload, ±1.
- Reset mid-operation: everything returns to reset values immediately. No RELEASE is emitted for a key that was pressed.

## Configuration

- `REMOTE_HOLD_EN` defined: HOLD events and the HELD state exist as described above.
- `REMOTE_HOLD_EN` undefined:
  - Repeats only reload the timer; no HOLD event is ever generated.
  - `hold_led` is tied to 0.
  - The repeat counter is removed.

## Structure

- Shared package `remote_pkg`:
  - key_type encodings `KEY_PRESS`=2'd0, `KEY_HOLD`=2'd1, `KEY_RELEASE`=2'd2.
  - FSM state typedef.
  - Width helpers for the event word (10 bits: type + code).
- One sub-module, `key_evt_fifo`: a synchronous FIFO with `FIFO_DEPTH`×10 bits, count-based full/empty, and overflow output.

## Test plan

Bench uses `CLK_FREQ`=1000, `RELEASE_MS`=10 (10-cycle timeout), `HOLD_RPT`=2.

- Single press: `data_en` with 0x45, `key_ready`=1 → PRESS 0x45 one cycle later, `disp_data`=0x45; no pulses for 10 cycles → RELEASE 0x45.
- Hold: press 0x16, then four repeats at 5-cycle spacing → events PRESS, HOLD, HOLD, HOLD; `hold_led`=1 from the 2nd repeat; RELEASE follows after the timeout.
- Code change: press 0x0C, then `data_en` with 0x18 → RELEASE 0x0C and PRESS 0x18 on consecutive cycles; `disp_data`=0x18.
- Backpressure: `key_ready`=0, generate 5 events → the first 4 are retained, `ovf`=1; drain → codes come out in order.
- Boundary: `repeat_en` on the exact cycle the timer reaches 0 → no RELEASE, timer reloaded; orphan `repeat_en` in IDLE → no event.
- Rebuild without `REMOTE_HOLD_EN` and rerun the hold scenario → only PRESS then RELEASE; `hold_led` stays 0.
